// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      BLANK = 2'd2
   } state_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;
   localparam logic [7:0] LIT_OFF = 8'hFF;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Full active-low segment byte {dp,g,f,e,d,c,b,a}.
   function automatic logic [7:0] seg_pat(input logic [3:0] val, input logic dp);
      return {~dp, HEX_SEG[val]};
   endfunction

endpackage

// File: rtl/seg7_digit_dec.sv
// Combinational 3-to-8 active-low one-hot digit select decoder.
module seg7_digit_dec
   import seg7_pkg::*;
(
   input  logic [2:0] idx,
   input  logic       en,
   output logic [7:0] lit_n
);

   always_comb begin
      lit_n = LIT_OFF;
      if (en) lit_n[idx] = 1'b0;
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 8-digit seven-segment scan controller with host write
// port, programmable dwell, optional blank gap between digits and frame tick.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] dig_en,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic       wr_dp,
   output logic [7:0] lit,
   output logic [7:0] seg,
   output logic [2:0] scan_idx,
   output logic       frame_tick
);

   localparam logic [15:0] SHOW_LAST  = 16'(SCAN_DIV - 1);
   localparam logic [15:0] BLANK_LAST = (BLANK_CYC > 0) ? 16'(BLANK_CYC - 1) : 16'd0;

   state_t          state, state_n;
   logic [15:0]     cnt, cnt_n;
   logic [2:0]      idx_n;
   logic            tick_n;
   logic [7:0][3:0] dval;
   logic [7:0]      dpv;
   logic            on;
   logic [7:0]      lit_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         scan_idx   <= '0;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         scan_idx   <= idx_n;
         frame_tick <= tick_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = scan_idx;
      tick_n  = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               state_n = SHOW;
               cnt_n   = '0;
               idx_n   = '0;
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  cnt_n = '0;
                  if (BLANK_CYC > 0) begin
                     state_n = BLANK;
                  end else begin
                     idx_n  = scan_idx + 3'd1;
                     tick_n = (scan_idx == 3'd7);
                  end
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
            BLANK: begin
               if (cnt == BLANK_LAST) begin
                  cnt_n   = '0;
                  state_n = SHOW;
                  idx_n   = scan_idx + 3'd1;
                  tick_n  = (scan_idx == 3'd7);
               end else begin
                  cnt_n = cnt + 16'd1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
               idx_n   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dval <= '0;
         dpv  <= '0;
      end else if (wr_en) begin
         dval[wr_addr] <= wr_data;
         dpv[wr_addr]  <= wr_dp;
      end
   end

   // Masked digits keep their slot timing; only the drive is suppressed.
   assign on = (state == SHOW) && dig_en[scan_idx];

   seg7_digit_dec u_dec (
      .idx   (scan_idx),
      .en    (on),
      .lit_n (lit_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lit <= LIT_OFF;
         seg <= SEG_OFF;
      end else begin
         lit <= lit_n;
         seg <= on ? seg_pat(dval[scan_idx], dpv[scan_idx]) : SEG_OFF;
      end
   end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: two instances (with and without blank
// gap) checked every cycle against a frame-position arithmetic model.
module tb_seg7_scan_ctrl;

   logic       clk, rst_n, en, wr_en, wr_dp;
   logic [7:0] dig_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;

   logic [7:0] lit [2];
   logic [7:0] seg [2];
   logic [2:0] sidx [2];
   logic       tick [2];

   seg7_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .en(en), .dig_en(dig_en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
      .lit(lit[0]), .seg(seg[0]), .scan_idx(sidx[0]), .frame_tick(tick[0])
   );

   seg7_scan_ctrl #(.SCAN_DIV(2), .BLANK_CYC(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .en(en), .dig_en(dig_en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_dp(wr_dp),
      .lit(lit[1]), .seg(seg[1]), .scan_idx(sidx[1]), .frame_tick(tick[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Active-low {g..a} patterns straight from the display datasheet table.
   logic [6:0] hexp [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int   sd [2] = '{4, 2};
   int   bc [2] = '{1, 0};

   // Model: p counts edges since scan start; slot/digit/phase by plain arithmetic.
   bit         act [2];
   int         p [2];
   logic [3:0] m_val [8];
   logic       m_dp [8];
   logic [7:0] e_lit [2], e_seg [2];
   logic [2:0] e_idx [2];
   logic       e_tick [2];

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         act[d] = 0; p[d] = 0;
         e_lit[d] = 8'hFF; e_seg[d] = 8'hFF; e_idx[d] = 3'd0; e_tick[d] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
         m_val[i] = 4'd0; m_dp[i] = 1'b0;
      end
   endtask

   task automatic compare();
      for (int d = 0; d < 2; d++) begin
         chk(d ? "lit_b" : "lit_a", lit[d], e_lit[d]);
         chk(d ? "seg_b" : "seg_a", seg[d], e_seg[d]);
         chk(d ? "idx_b" : "idx_a", {5'd0, sidx[d]}, {5'd0, e_idx[d]});
         chk(d ? "tick_b" : "tick_a", {7'd0, tick[d]}, {7'd0, e_tick[d]});
      end
   endtask

   // Advance model across one rising edge using the inputs now applied, then check.
   task automatic cyc();
      int         per, ix;
      bit         on;
      logic [7:0] one;
      one = 8'h01;
      for (int d = 0; d < 2; d++) begin
         per = sd[d] + bc[d];
         ix  = act[d] ? (p[d] / per) % 8 : 0;
         on  = act[d] && ((p[d] % per) < sd[d]) && dig_en[ix];
         e_lit[d] = on ? ~(one << ix) : 8'hFF;
         e_seg[d] = on ? {~m_dp[ix], hexp[m_val[ix]]} : 8'hFF;
         if (!en) begin
            act[d] = 0; p[d] = 0;
         end else if (!act[d]) begin
            act[d] = 1; p[d] = 0;
         end else begin
            p[d]++;
         end
         e_idx[d]  = act[d] ? 3'((p[d] / per) % 8) : 3'd0;
         e_tick[d] = act[d] && (p[d] > 0) && (p[d] % (8 * per) == 0);
      end
      if (wr_en) begin
         m_val[wr_addr] = wr_data;
         m_dp[wr_addr]  = wr_dp;
      end
      @(negedge clk);
      compare();
      wr_en = 1'b0;
   endtask

   task automatic wr(input logic [2:0] a, input logic [3:0] v, input logic dp);
      wr_en = 1'b1; wr_addr = a; wr_data = v; wr_dp = dp;
      cyc();
   endtask

   task automatic rand_cycles(input int n);
      for (int k = 0; k < n; k++) begin
         if ($urandom_range(0, 299) == 0) en = ~en;
         else if (!en && $urandom_range(0, 7) == 0) en = 1'b1;
         if ($urandom_range(0, 99) == 0)
            dig_en = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 5) == 0) begin
            wr_en = 1'b1; wr_addr = 3'($urandom); wr_data = 4'($urandom); wr_dp = 1'($urandom);
         end
         cyc();
      end
   endtask

   // Asynchronous reset pulse: outputs must clear without waiting for a clock.
   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      compare();
      @(negedge clk);
      rst_n = 1'b1;
      compare();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; dig_en = 8'hFF;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dp = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      compare();
      rst_n = 1'b1;

      // Plain scan with blank digits.
      en = 1'b1;
      repeat (100) cyc();

      wr(3'd3, 4'hA, 1'b1);
      wr(3'd5, 4'h7, 1'b0);
      repeat (90) cyc();

      dig_en = 8'b1111_1011;
      repeat (90) cyc();
      dig_en = 8'hFF;

      // Write to digit 0 while it owns the slot.
      while (lit[0] !== 8'hFE) cyc();
      wr(3'd0, 4'h9, 1'b0);
      repeat (20) cyc();

      // Drop enable mid-slot and restart.
      en = 1'b0;
      repeat (5) cyc();
      en = 1'b1;
      repeat (60) cyc();

      rand_cycles(1500);
      en = 1'b1;
      repeat (23) cyc();
      pulse_reset();
      en = 1'b1;
      repeat (60) cyc();
      rand_cycles(1500);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
